// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus for imem_loader.
// master = stream producer / memory side, slave = the loader.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: length, little-endian instruction
// bytes and an XOR checksum; the core is held in reset until a good load.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] count;
  logic [15:0] index;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic [23:0] word_lo;
  logic        rdy;
  logic        we;
  logic        accept;
  logic [15:0] len_in;
  logic [15:0] index_nxt;

  assign accept    = bus.byte_valid & rdy;
  assign len_in    = {bus.byte_data, count[7:0]};
  assign index_nxt = index + 16'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = LEN_LO;
      LEN_LO: if (accept) state_n = LEN_HI;
      LEN_HI:
        if (accept) begin
          if (32'(len_in) > 32'(DEPTH_WORDS)) state_n = ERR;
          else if (len_in == '0)              state_n = CHECK;
          else                                state_n = DATA;
        end
      DATA:   if (accept && bcnt == 2'd3) state_n = WRITE;
      WRITE:  state_n = (index_nxt == count) ? CHECK : DATA;
      CHECK:
        if (accept) state_n = (bus.byte_data == csum) ? DONE : ERR;
      DONE:   if (start) state_n = LEN_LO;
      ERR:    if (start) state_n = LEN_LO;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rdy      = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state)
      LEN_LO, LEN_HI, DATA, CHECK: rdy = 1'b1;
      WRITE: we = 1'b1;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:  error = 1'b1;
      default: ;
    endcase
  end

  assign bus.byte_ready = rdy;
  assign bus.mem_we     = we;

  // Address and data are latched with the 4th byte so they are stable for
  // the whole WRITE cycle and hold afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      index         <= '0;
      bcnt          <= '0;
      csum          <= '0;
      word_lo       <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE, DONE, ERR:
          if (start) begin
            index <= '0;
            bcnt  <= '0;
            csum  <= '0;
          end
        LEN_LO: if (accept) count[7:0]  <= bus.byte_data;
        LEN_HI: if (accept) count[15:8] <= bus.byte_data;
        DATA:
          if (accept) begin
            csum <= csum ^ bus.byte_data;
            bcnt <= bcnt + 2'd1;
            unique case (bcnt)
              2'd0: word_lo[7:0]   <= bus.byte_data;
              2'd1: word_lo[15:8]  <= bus.byte_data;
              2'd2: word_lo[23:16] <= bus.byte_data;
              default: begin
                bus.mem_addr  <= BASE_ADDR + {14'b0, index, 2'b00};
                bus.mem_wdata <= {bus.byte_data, word_lo};
              end
            endcase
          end
        WRITE: begin
          index <= index_nxt;
          bcnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
